pc_seq: RTL and testbench
=========================

# pc_seq

Parametrised program-counter sequencer for the picoMIPS core. It replaces the plain increment/hold PC with one that can stall, branch absolute or PC-relative, and handle call/return through an internal return-address stack (RAS). PCout addresses program memory directly; all control inputs come from the decoder and are sampled on the rising clock edge.

## Interface
- Psize, 6: PC and program-address width in bits.
- RAS_DEPTH, 4: number of return-address stack entries, ≥ 2.
- RESET_ADDR, 0: value loaded into PCout on reset, Psize bits.

- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- stall  in  1  hold PC and stack; overrides every other control.
- branch  in  1  load the branch target.
- branch_abs  in  1  1: target is an absolute address; 0: target is a signed two's-complement offset added to PCout.
- call  in  1  push PCout+1 and jump to the absolute target.
- ret  in  1  pop the top entry into PC.
- target  in  Psize  branch or call address/offset.
- PCout  out  Psize  current instruction address.
- ras_full  out  1  stack holds RAS_DEPTH entries.
- ras_empty  out  1  stack holds 0 entries.
- ras_err  out  1  sticky flag for overflow, underflow or illegal combination; cleared only by reset.

## Operation
- Priority at each edge is reset > stall > (call&ret) > ret > call > branch > increment.
- Increment: PCout ← PCout+1 mod 2^Psize. Address 2^Psize−1 wraps to 0 with no flag.
- branch, branch_abs=1: PCout ← target.
- branch, branch_abs=0: PCout ← PCout + sign-extended target, mod 2^Psize. Offset 0 holds the PC.
- call: push (PCout+1 mod 2^Psize), then PCout ← target (always absolute, branch_abs is ignored).
  - When full, the oldest entry is overwritten (circular), the count stays RAS_DEPTH, and ras_err is set.
- ret: PCout ← top entry, then pop.
  - When empty, PCout increments, the stack is unchanged, and ras_err is set.
- call and ret asserted together is illegal: PCout increments, the stack is unchanged, and ras_err is set.
- branch asserted together with call or ret is ignored.
- Stack implementation:
  - RAS_DEPTH×Psize register array, a circular top pointer, and an occupancy count of $clog2(RAS_DEPTH+1) bits.
  - ras_full is (count == RAS_DEPTH); ras_empty is (count == 0). Both are decoded from registered state.
- stall freezes PCout, the stack, the count and ras_err. Controls present during stall are discarded, not queued.

## Timing
- Reset (asynchronous, takes effect immediately, independent of clk): PCout=RESET_ADDR, count=0, ras_empty=1, ras_full=0, ras_err=0.
- Stack contents are don't-care after reset.
- Reset asserted mid-operation aborts any pending action. The first edge after deassertion performs a normal step from RESET_ADDR.
- All updates happen on the rising clk edge. A control sampled at edge n is visible on PCout after edge n, i.e. 1-cycle latency and no combinational path from inputs to outputs.
- ras_err rises in the same edge as the offending operation.
- Back-to-back call/ret on consecutive cycles is supported at full rate with no bubble.

## Configuration
- PC_RAS_EN defined: the return stack and the call/ret behaviour are as above.
- PC_RAS_EN undefined: the stack array, pointer and count are not built.
  - call acts as an absolute branch with no push.
  - ret acts as an increment.
  - call and ret together acts as an increment with no error.
  - ras_full=0, ras_empty=1 and ras_err=0 are tied constant.

## Test plan
All scenarios use Psize=6, RAS_DEPTH=4, RESET_ADDR=0, PC_RAS_EN defined unless noted.
- Reset: run 7 increments, then assert reset mid-cycle → PCout=0 immediately with no clk edge, ras_empty=1, ras_err=0. After release, the next edge gives PCout=1.
- Wrap and stall:
  - Increment from 62 → 63 → 0.
  - stall=1 with branch=1, target=20 for 3 edges → PCout holds 0 throughout.
  - After stall drops, a plain increment gives PCout=1.
- Relative branch:
  - PCout=10, branch=1, branch_abs=0, target=6'b111100 (−4) → PCout=6.
  - target=6'b000011 → PCout=9.
  - From PCout=62, target=+5 → PCout=3.
- Call/ret:
  - PCout=5, call, target=20 → PCout=20, ras_empty=0.
  - A nested call at 20 to 40 → PCout=40.
  - ret → PCout=21; ret → PCout=6, ras_empty=1, ras_err=0.
- Overflow/underflow:
  - 4 calls → ras_full=1, ras_err=0.
  - A 5th call from PC p → ras_err=1 and the oldest entry is lost; the first ret then returns p+1.
  - Then 3 more rets → ras_empty=1.
  - A further ret from PCout=q → PCout=q+1, and ras_err stays 1 until reset.
- Illegal combination and compile-out:
  - call and ret together at PCout=12 → PCout=13, ras_err=1, count unchanged.
  - Rebuild without PC_RAS_EN: call with target=30 → PCout=30; ret → 31; ras_err stays 0.

Source files
------------

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer for the picoMIPS core.
//
// Replaces the plain increment/hold PC. The sequencer can stall, take an
// absolute or PC-relative branch, and handle call/return through an internal
// circular return-address stack (RAS).
//
// Build option:
//   PC_RAS_EN  when defined, the return stack is built and call/ret push/pop it.
//              When undefined, call is a plain absolute jump, ret is an
//              increment, and the stack status outputs are tied off.
//
// Parameters:
//   Psize       PC / program-address width in bits
//   RAS_DEPTH   number of return-stack entries (at least 2)
//   RESET_ADDR  PC value loaded on reset
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   stall       hold PC, stack and error flag; discards all other controls
//   branch      load branch target (ignored together with call or ret)
//   branch_abs  1: target is absolute, 0: target is a signed offset from PCout
//   call        push PCout+1 and jump to the absolute target
//   ret         pop the top stack entry into the PC
//   target      branch/call address or signed offset
//   PCout       current instruction address
//   ras_full    stack holds RAS_DEPTH entries
//   ras_empty   stack holds no entries
//   ras_err     sticky overflow/underflow/illegal-combination flag
module pc_seq #(
    parameter int unsigned      Psize      = 6,
    parameter int unsigned      RAS_DEPTH  = 4,
    parameter logic [Psize-1:0] RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch,
    input  logic             branch_abs,
    input  logic             call,
    input  logic             ret,
    input  logic [Psize-1:0] target,
    output logic [Psize-1:0] PCout,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             ras_err
);

    if (RAS_DEPTH < 2) begin : g_bad_depth
        $error("pc_seq: RAS_DEPTH must be at least 2");
    end

    logic [Psize-1:0] pc_q, pc_d;
    logic [Psize-1:0] pc_inc;
    logic [Psize-1:0] pc_br;

    // Adding the raw offset bits at Psize width is the same as adding the
    // sign-extended offset modulo 2^Psize, so no explicit extension is needed.
    assign pc_inc = pc_q + 1'b1;
    assign pc_br  = branch_abs ? target : pc_q + target;

`ifdef PC_RAS_EN
    localparam int unsigned      PTR_W    = $clog2(RAS_DEPTH);
    localparam int unsigned      CNT_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [Psize-1:0] ras_q [RAS_DEPTH];
    logic [Psize-1:0] ras_d [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [PTR_W-1:0] top_up, top_dn;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             full, empty;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // The top pointer wraps explicitly so that depths that are not powers of
    // two still cycle through exactly RAS_DEPTH slots. When the stack is full
    // the slot above top holds the oldest entry, so a push there overwrites it.
    assign top_up = (top_q == PTR_LAST) ? '0 : top_q + 1'b1;
    assign top_dn = (top_q == '0) ? PTR_LAST : top_q - 1'b1;

    // Next-state for PC and stack, in priority order:
    // stall > call&ret > ret > call > branch > increment.
    always_comb begin
        pc_d    = pc_q;
        ras_d   = ras_q;
        top_d   = top_q;
        count_d = count_q;
        err_d   = err_q;
        if (!stall) begin
            if (call && ret) begin
                pc_d  = pc_inc;
                err_d = 1'b1;
            end else if (ret) begin
                if (empty) begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end else begin
                    pc_d    = ras_q[top_q];
                    top_d   = top_dn;
                    count_d = count_q - 1'b1;
                end
            end else if (call) begin
                ras_d[top_up] = pc_inc;
                top_d         = top_up;
                pc_d          = target;
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else if (branch) begin
                pc_d = pc_br;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // Control state: PC, pointer, occupancy and the sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_ADDR;
            top_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            top_q   <= top_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Stack storage has no reset; its contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end

    assign ras_full  = full;
    assign ras_empty = empty;
    assign ras_err   = err_q;
`else
    // Without the stack, call is a plain absolute jump and ret (alone or
    // together with call) falls back to an increment.
    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            if (call && !ret) begin
                pc_d = target;
            end else if (call || ret) begin
                pc_d = pc_inc;
            end else if (branch) begin
                pc_d = pc_br;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign ras_full  = 1'b0;
    assign ras_empty = 1'b1;
    assign ras_err   = 1'b0;
`endif

    assign PCout = pc_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: self-checking bench for pc_seq (Psize=6, RAS_DEPTH=4,
// RESET_ADDR=0). Directed scenarios followed by random control sequences,
// all checked against a queue-based behavioural model of the sequencer.
module tb_pc_seq;

   localparam int P     = 6;
   localparam int MOD   = 1 << P;
   localparam int DEPTH = 4;

   logic         clk;
   logic         reset;
   logic         stall;
   logic         branch;
   logic         branch_abs;
   logic         call;
   logic         ret;
   logic [P-1:0] target;
   logic [P-1:0] PCout;
   logic         ras_full;
   logic         ras_empty;
   logic         ras_err;

   int errors = 0;
   int checks = 0;

   // Behavioural model state: PC as an integer, stack as a queue whose back
   // is the most recent return address.
   int mPc;
   int mRas[$];
   bit mErr;

   pc_seq #(
      .Psize     (P),
      .RAS_DEPTH (DEPTH),
      .RESET_ADDR(6'd0)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .branch    (branch),
      .branch_abs(branch_abs),
      .call      (call),
      .ret       (ret),
      .target    (target),
      .PCout     (PCout),
      .ras_full  (ras_full),
      .ras_empty (ras_empty),
      .ras_err   (ras_err)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the bench can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic modelReset();
      mPc = 0;
      mRas.delete();
      mErr = 1'b0;
   endtask

   // One clock edge of the sequencer described at the level of its rules.
   task automatic modelStep(input bit s, input bit b, input bit a,
                            input bit c, input bit r, input int t);
      int off;
      if (s) return;
`ifdef PC_RAS_EN
      if (c && r) begin
         mErr = 1'b1;
         mPc = (mPc + 1) % MOD;
         return;
      end
      if (r) begin
         if (mRas.size() == 0) begin
            mErr = 1'b1;
            mPc = (mPc + 1) % MOD;
         end else begin
            mPc = mRas.pop_back();
         end
         return;
      end
      if (c) begin
         if (mRas.size() == DEPTH) begin
            void'(mRas.pop_front());
            mErr = 1'b1;
         end
         mRas.push_back((mPc + 1) % MOD);
         mPc = t;
         return;
      end
`else
      if (c && !r) begin
         mPc = t;
         return;
      end
      if (r) begin
         mPc = (mPc + 1) % MOD;
         return;
      end
`endif
      if (b) begin
         if (a) begin
            mPc = t;
         end else begin
            off = (t >= MOD / 2) ? t - MOD : t;
            mPc = (mPc + off + MOD) % MOD;
         end
         return;
      end
      mPc = (mPc + 1) % MOD;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      checks++;
      assert (obs === 32'(exp)) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      check({tag, ".PCout"}, 32'(PCout), mPc);
      check({tag, ".ras_empty"}, 32'(ras_empty), int'(mRas.size() == 0));
      check({tag, ".ras_full"}, 32'(ras_full), int'(mRas.size() == DEPTH));
      check({tag, ".ras_err"}, 32'(ras_err), int'(mErr));
   endtask

   // Drives one cycle of controls (called just after an edge), lets the
   // model and DUT take the next rising edge, then checks 1 ns later.
   task automatic applyStimulus(input bit s, input bit b, input bit a,
                                input bit c, input bit r, input int t,
                                input string tag);
      stall      = s;
      branch     = b;
      branch_abs = a;
      call       = c;
      ret        = r;
      target     = P'(t);
      modelStep(s, b, a, c, r, t);
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   // Asserts reset between edges and checks that it acts without a clock.
   task automatic applyReset(input string tag);
      #2;
      reset = 1'b1;
      #1;
      modelReset();
      checkOutput(tag);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      stall      = 1'b0;
      branch     = 1'b0;
      branch_abs = 1'b0;
      call       = 1'b0;
      ret        = 1'b0;
      target     = '0;
      modelReset();
      #3;
      checkOutput("reset_initial");
      #1;
      reset = 1'b0;

      // Increments, then an asynchronous reset between edges.
      for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, 0, 0, "inc7");
      applyReset("reset_midcycle");
      applyStimulus(0, 0, 0, 0, 0, 0, "after_reset_inc");

      // Wrap and stall.
      applyStimulus(0, 1, 1, 0, 0, 62, "set62");
      applyStimulus(0, 0, 0, 0, 0, 0, "inc63");
      applyStimulus(0, 0, 0, 0, 0, 0, "wrap0");
      for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 0, 20, "stall_hold");
      applyStimulus(0, 0, 0, 0, 0, 0, "after_stall_inc");

      // Relative branches.
      applyStimulus(0, 1, 1, 0, 0, 10, "set10");
      applyStimulus(0, 1, 0, 0, 0, 6'b111100, "rel_minus4");
      applyStimulus(0, 1, 0, 0, 0, 6'b000011, "rel_plus3");
      applyStimulus(0, 1, 1, 0, 0, 62, "set62b");
      applyStimulus(0, 1, 0, 0, 0, 5, "rel_wrap");
      applyStimulus(0, 1, 0, 0, 0, 0, "rel_zero");

`ifdef PC_RAS_EN
      // Nested call/ret.
      applyStimulus(0, 1, 1, 0, 0, 5, "set5");
      applyStimulus(0, 0, 0, 1, 0, 20, "call20");
      applyStimulus(0, 0, 0, 1, 0, 40, "call40");
      applyStimulus(0, 0, 0, 0, 1, 0, "ret21");
      applyStimulus(0, 0, 0, 0, 1, 0, "ret6");

      // Overflow, then drain and underflow.
      applyStimulus(0, 0, 0, 1, 0, 10, "fill1");
      applyStimulus(0, 0, 0, 1, 0, 20, "fill2");
      applyStimulus(0, 0, 0, 1, 0, 30, "fill3");
      applyStimulus(0, 0, 0, 1, 0, 40, "fill4");
      applyStimulus(0, 1, 1, 1, 0, 50, "overflow_call");
      applyStimulus(0, 0, 0, 0, 1, 0, "ret_after_overflow");
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0, "drain");
      applyStimulus(0, 0, 0, 0, 1, 0, "underflow_ret");
      applyStimulus(0, 0, 0, 0, 0, 0, "err_sticky");
      applyStimulus(1, 0, 0, 0, 1, 0, "stall_ret");

      // Illegal call+ret with one entry on the stack.
      applyReset("reset_clear_err");
      applyStimulus(0, 1, 1, 0, 0, 3, "set3");
      applyStimulus(0, 0, 0, 1, 0, 12, "call12");
      applyStimulus(0, 1, 1, 1, 1, 33, "call_and_ret");
      applyStimulus(0, 0, 0, 0, 1, 0, "ret_after_illegal");
`else
      // Stack compiled out.
      applyStimulus(0, 0, 0, 1, 0, 30, "call_no_ras");
      applyStimulus(0, 0, 0, 0, 1, 0, "ret_no_ras");
      applyStimulus(0, 0, 0, 1, 1, 5, "call_ret_no_ras");
      applyStimulus(0, 1, 0, 1, 0, 7, "call_abs_no_ras");
`endif

      // Random control sequences.
      applyReset("reset_before_random");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom % 8) == 0, ($urandom % 3) == 0,
                       ($urandom % 2) == 1, ($urandom % 4) == 0,
                       ($urandom % 4) == 0, int'($urandom % MOD), "random");
         if (($urandom % 64) == 0) applyReset("random_reset");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
